// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one sqrt32 core among NREQ requesters.
// Sequences the core through load/run/response phases and guards each run with a watchdog.
module sqrt_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [15:0]          resp_y,
    output logic                 resp_err,
    output logic                 sq_reset,
    output logic [31:0]          sq_x,
    input  logic                 sq_rdy,
    input  logic [15:0]          sq_y
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [31:0]     x_q, x_d;
    logic [15:0]     y_q, y_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        any_req = 1'b0;
        pick    = ptr_q;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_q) + k) % 32'(NREQ));
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    ptr_d   = PW'((32'(pick) + 32'd1) % 32'(NREQ));
                    x_d     = req_x[32*pick +: 32];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // cnt_q==0 marks the first RUN cycle, where sq_rdy may still be stale.
                if (cnt_q != '0 && sq_rdy) begin
                    y_d     = sq_y;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        sq_reset   = 1'b1;
        if (state_q == IDLE && any_req && !reset) begin
            req_ready[pick] = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid[gnt_q] = 1'b1;
        end
        if (state_q == RUN) begin
            sq_reset = 1'b0;
        end
    end

    assign sq_x     = x_q;
    assign resp_y   = y_q;
    assign resp_err = err_q;

endmodule
